// File: rtl/music_pkg.sv
// Shared types and event-word layout for the song sequencer.
// Pure declarations, no logic and no latency.
// Imported by the sequencer top; the tick prescaler is standalone.
package music_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_FETCH  = 2'd1,
        ST_DECODE = 2'd2,
        ST_PLAY   = 2'd3
    } state_t;

    // Event word: note code in the upper byte, duration in ticks in the lower byte
    localparam int NOTE_MSB = 15;
    localparam int NOTE_LSB = 8;
    localparam int DUR_MSB  = 7;
    localparam int DUR_LSB  = 0;

    // A zero duration marks the end of the song; a zero note is a rest
    localparam logic [7:0] END_DURATION = 8'd0;
    localparam logic [7:0] REST_NOTE    = 8'd0;

endpackage

// File: rtl/tempo_tick.sv
// Tempo prescaler: one-cycle tick every TICK_DIV clk cycles.
// Tick asserts combinationally in the last count of each period.
// No backpressure; restart forces the count back to 0 on the next edge.
module tempo_tick #(
    parameter int TICK_DIV = 390625
) (
    input  logic clk,
    input  logic resetn,
    input  logic restart,
    output logic tick
);

    localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(TICK_DIV - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Next count: wrap at the end of the period or jump to 0 on restart
    always_comb begin
        cnt_d = cnt_q + 1'b1;
        if (restart || (cnt_q == LAST)) begin
            cnt_d = '0;
        end
    end

    // Count register with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!resetn) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tick = (cnt_q == LAST);

endmodule

// File: rtl/song_sequencer.sv
// Song sequencer: fetches timed note events from a sync ROM and drives fullnote/gate.
// Start to first note valid is 3 edges (FETCH, DECODE, PLAY); 2 idle cycles between notes.
// No backpressure; stop aborts from any state, start is ignored while busy.
module song_sequencer
    import music_pkg::*;
#(
    parameter int TICK_DIV  = 390625,
    parameter int ADDR_W    = 8,
    parameter int GAP_TICKS = 1
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              start,
    input  logic              stop,
    input  logic              loop_en,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [15:0]       rom_data,
    output logic [7:0]        fullnote,
    output logic              gate,
    output logic              busy,
    output logic              done
);

    localparam logic [7:0] GAP = 8'(GAP_TICKS);

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [7:0]        dur_q, dur_d;
    logic [7:0]        note_q, note_d;
    logic              gate_q, gate_d;
    logic              done_q, done_d;
    logic              restart;
    logic              tick;

    logic [7:0] ev_note;
    logic [7:0] ev_dur;
    logic [7:0] dur_dec;

    assign ev_note = rom_data[NOTE_MSB:NOTE_LSB];
    assign ev_dur  = rom_data[DUR_MSB:DUR_LSB];
    assign dur_dec = dur_q - 8'd1;

    tempo_tick #(
        .TICK_DIV (TICK_DIV)
    ) u_tempo_tick (
        .clk     (clk),
        .resetn  (resetn),
        .restart (restart),
        .tick    (tick)
    );

    // Next-state and output-register logic; stop outranks every other transition
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        dur_d   = dur_q;
        note_d  = note_q;
        gate_d  = gate_q;
        done_d  = 1'b0;
        restart = 1'b0;

        if (stop && (state_q != ST_IDLE)) begin
            state_d = ST_IDLE;
            addr_d  = '0;
            note_d  = REST_NOTE;
            gate_d  = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start && !stop) begin
                        state_d = ST_FETCH;
                    end
                end
                ST_FETCH: begin
                    state_d = ST_DECODE;
                end
                ST_DECODE: begin
                    if (ev_dur == END_DURATION) begin
                        addr_d = '0;
                        if (loop_en) begin
                            state_d = ST_FETCH;
                        end else begin
                            done_d  = 1'b1;
                            note_d  = REST_NOTE;
                            gate_d  = 1'b0;
                            state_d = ST_IDLE;
                        end
                    end else begin
                        note_d  = ev_note;
                        dur_d   = ev_dur;
                        restart = 1'b1;
                        gate_d  = (ev_note != REST_NOTE) && (ev_dur > GAP);
                        state_d = ST_PLAY;
                    end
                end
                ST_PLAY: begin
                    if (tick) begin
                        dur_d = dur_dec;
                        // Articulation gap: silence the last GAP_TICKS of the note
                        if (dur_dec == GAP) begin
                            gate_d = 1'b0;
                        end
                        if (dur_dec == 8'd0) begin
                            gate_d  = 1'b0;
                            addr_d  = addr_q + 1'b1;
                            state_d = ST_FETCH;
                        end
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    // State and output registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q <= ST_IDLE;
            addr_q  <= '0;
            dur_q   <= '0;
            note_q  <= '0;
            gate_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            dur_q   <= dur_d;
            note_q  <= note_d;
            gate_q  <= gate_d;
            done_q  <= done_d;
        end
    end

    assign rom_addr = addr_q;
    assign fullnote = note_q;
    assign gate     = gate_q;
    assign done     = done_q;
    assign busy     = (state_q != ST_IDLE);

endmodule

// File: tb/tb_song_sequencer.sv
// Scoreboard bench for song_sequencer: a per-event reference model predicts the
// cycle trace of every busy/done cycle, a monitor pops and compares on each one.
// Directed cases for the listed scenarios, then randomized ROMs, loops and aborts.
module tb_song_sequencer;

    localparam int T    = 4;
    localparam int GAP  = 1;
    localparam int AW   = 2;
    localparam int NROM = 4;

    typedef struct packed {
        logic [1:0] addr;
        logic [7:0] note;
        logic       gate;
        logic       busy;
        logic       done;
    } exp_t;

    logic          clk;
    logic          resetn;
    logic          start;
    logic          stop;
    logic          loop_en;
    logic [AW-1:0] rom_addr;
    logic [15:0]   rom_data;
    logic [7:0]    fullnote;
    logic          gate;
    logic          busy;
    logic          done;

    logic [15:0] rom [NROM];
    exp_t        exp_q[$];
    int          errors;
    int          checks;
    bit          mon_on;

    song_sequencer #(
        .TICK_DIV  (T),
        .ADDR_W    (AW),
        .GAP_TICKS (GAP)
    ) dut (
        .clk      (clk),
        .resetn   (resetn),
        .start    (start),
        .stop     (stop),
        .loop_en  (loop_en),
        .rom_addr (rom_addr),
        .rom_data (rom_data),
        .fullnote (fullnote),
        .gate     (gate),
        .busy     (busy),
        .done     (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous song ROM: data valid one cycle after the address
    always @(posedge clk) rom_data <= rom[rom_addr];

    function automatic exp_t mk(input int a, input logic [7:0] n, input bit g,
                                input bit b, input bit d);
        exp_t e;
        logic [1:0] a2;
        a2 = a[1:0];
        e.addr = a2;
        e.note = n;
        e.gate = g;
        e.busy = b;
        e.done = d;
        return e;
    endfunction

    function automatic exp_t observe();
        exp_t o;
        o.addr = rom_addr;
        o.note = fullnote;
        o.gate = gate;
        o.busy = busy;
        o.done = done;
        return o;
    endfunction

    // Monitor: every cycle the DUT shows busy or done must match the next prediction
    always @(negedge clk) begin
        if (mon_on && (busy || done)) begin
            exp_t e;
            exp_t o;
            o = observe();
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_output got addr=%0d note=%0d gate=%0b busy=%0b done=%0b, none expected",
                         o.addr, o.note, o.gate, o.busy, o.done);
            end else begin
                e = exp_q.pop_front();
                if (o !== e) begin
                    errors++;
                    $display("FAIL trace got addr=%0d note=%0d gate=%0b busy=%0b done=%0b expected addr=%0d note=%0d gate=%0b busy=%0b done=%0b",
                             o.addr, o.note, o.gate, o.busy, o.done,
                             e.addr, e.note, e.gate, e.busy, e.done);
                end
            end
        end
    end

    // Reference model: walk the song event by event and list the visible cycles.
    // Each event costs FETCH+DECODE, then d*T play cycles with gate high for (d-GAP)*T.
    // If an abort is requested (cut>0) or the song never ends, keep only the first cut cycles.
    task automatic build(input bit lp, input int cut_in, output int cut_out, output int len);
        exp_t       tr[$];
        int         a;
        int         d;
        int         cap;
        bit         term;
        bit         g;
        logic [7:0] n;
        logic [7:0] np;
        logic [15:0] w;
        a    = 0;
        np   = 8'd0;
        term = 1'b0;
        cap  = (cut_in > 0) ? cut_in : 150;
        while (!term && tr.size() < cap) begin
            tr.push_back(mk(a, np, 1'b0, 1'b1, 1'b0));
            tr.push_back(mk(a, np, 1'b0, 1'b1, 1'b0));
            w = rom[a];
            n = w[15:8];
            d = int'(w[7:0]);
            if (d == 0) begin
                if (lp) begin
                    a = 0;
                end else begin
                    tr.push_back(mk(0, 8'd0, 1'b0, 1'b0, 1'b1));
                    term = 1'b1;
                end
            end else begin
                g = (n != 8'd0) && (d > GAP);
                for (int c = 0; c < d * T; c++) begin
                    tr.push_back(mk(a, n, g && (c < (d - GAP) * T), 1'b1, 1'b0));
                end
                np = n;
                a  = (a + 1) % NROM;
            end
        end
        if (!term || (cut_in > 0 && tr.size() > cut_in)) begin
            while (tr.size() > cap) void'(tr.pop_back());
            cut_out = cap;
        end else begin
            cut_out = 0;
        end
        len = tr.size();
        foreach (tr[i]) exp_q.push_back(tr[i]);
    endtask

    task automatic check_idle(input string name);
        exp_t o;
        o = observe();
        checks++;
        if (o !== mk(0, 8'd0, 1'b0, 1'b0, 1'b0)) begin
            errors++;
            $display("FAIL %s got addr=%0d note=%0d gate=%0b busy=%0b done=%0b expected all zero",
                     name, o.addr, o.note, o.gate, o.busy, o.done);
        end
    endtask

    task automatic check_drained(input string name);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL %s got %0d predicted cycles never seen expected 0", name, exp_q.size());
            exp_q.delete();
        end
    endtask

    // Launch one song; optionally abort with stop (or resetn) so it lands at cycle cut,
    // and optionally pulse start while busy, which must change nothing.
    task automatic play(input string name, input bit lp, input int cut_in,
                        input bit use_rst, input bit glitch);
        int cut;
        int len;
        int last;
        int lim;
        @(negedge clk);
        build(lp, cut_in, cut, len);
        loop_en = lp;
        start   = 1'b1;
        last = (cut > 0) ? cut + 2 : len + 2;
        lim  = (cut > 0) ? cut : len - 1;
        for (int i = 1; i <= last; i++) begin
            @(negedge clk);
            start  = (glitch && i <= lim) ? ($urandom_range(0, 4) == 0) : 1'b0;
            stop   = (cut > 0 && i == cut && !use_rst);
            resetn = !(cut > 0 && i == cut && use_rst);
        end
        start  = 1'b0;
        stop   = 1'b0;
        resetn = 1'b1;
        #1;
        check_drained({name, "_drain"});
        check_idle({name, "_idle"});
    endtask

    task automatic load_rom(input logic [15:0] w0, input logic [15:0] w1,
                            input logic [15:0] w2, input logic [15:0] w3);
        rom[0] = w0;
        rom[1] = w1;
        rom[2] = w2;
        rom[3] = w3;
    endtask

    initial begin
        errors  = 0;
        checks  = 0;
        mon_on  = 1'b0;
        resetn  = 1'b0;
        start   = 1'b0;
        stop    = 1'b0;
        loop_en = 1'b0;
        load_rom(16'h1903, 16'h1B02, 16'h0000, 16'h0000);

        repeat (3) @(negedge clk);
        #1;
        check_idle("reset_state");
        resetn = 1'b1;
        mon_on = 1'b1;

        // Basic playback: 25 for 3 ticks, 27 for 2 ticks, then done
        play("basic", 1'b0, 0, 1'b0, 1'b0);

        // Rest event and a note no longer than the gap
        load_rom(16'h0003, 16'h1901, 16'h0000, 16'h0000);
        play("rest_short", 1'b0, 0, 1'b0, 1'b0);

        // Looping: end marker returns to address 0, no done; abort after a while
        load_rom(16'h1903, 16'h1B02, 16'h0000, 16'h0000);
        play("loop", 1'b1, 45, 1'b0, 1'b1);

        // Stop in the middle of the first note
        play("stop_mid", 1'b0, 7, 1'b0, 1'b0);

        // Reset in the middle of the first note
        play("reset_mid", 1'b0, 5, 1'b1, 1'b0);

        // Start with start pulses while busy
        play("start_busy", 1'b0, 0, 1'b0, 1'b1);

        // start and stop together from IDLE: nothing happens
        @(negedge clk);
        start = 1'b1;
        stop  = 1'b1;
        @(negedge clk);
        start = 1'b0;
        stop  = 1'b0;
        #1;
        check_idle("start_stop_idle");
        repeat (2) @(negedge clk);
        #1;
        check_drained("start_stop_drain");

        // No end marker: address wraps 0,1,2,3,0 and playback continues
        load_rom(16'h1901, 16'h1901, 16'h1901, 16'h1901);
        play("wrap", 1'b0, 30, 1'b0, 1'b0);

        // Randomized songs, loop settings, aborts and stray start pulses
        for (int r = 0; r < 14; r++) begin
            for (int k = 0; k < NROM; k++) begin
                logic [7:0] n;
                logic [7:0] d;
                n = ($urandom_range(0, 2) == 0) ? 8'd0 : 8'($urandom_range(1, 255));
                d = 8'($urandom_range(0, 4));
                rom[k] = {n, d};
            end
            play("random", 1'($urandom_range(0, 1)),
                 ($urandom_range(0, 2) == 0) ? 0 : $urandom_range(1, 60),
                 1'($urandom_range(0, 3) == 0), 1'b1);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
